// File: rtl/data_load_sequencer_if.sv
// data_load_sequencer_if: request/completion bundle between the load sequencer
// and the DMA/BRAM writer. The sequencer holds the master modport.
interface data_load_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 12
);
    logic              dma_req_valid;
    logic              dma_req_ready;
    logic              dma_req_type;   // 0 = weight, 1 = ifmap
    logic [ADDR_W-1:0] dma_req_addr;
    logic [LEN_W-1:0]  dma_req_len;
    logic              dma_done;       // 1-cycle pulse per accepted request

    modport master (
        output dma_req_valid, dma_req_type, dma_req_addr, dma_req_len,
        input  dma_req_ready, dma_done
    );

    modport slave (
        input  dma_req_valid, dma_req_type, dma_req_addr, dma_req_len,
        output dma_req_ready, dma_done
    );
endinterface

// File: rtl/data_load_sequencer.sv
// data_load_sequencer: walks the fixed 4-layer transposed-conv load schedule
// (ifmap + weight for batch 0 of a layer, weight only for later batches),
// issues DMA load requests and emits ifmap/weight write-done pulses, paced by
// the scheduler's start and batch-complete pulses.
// Optional macro LOAD_PREFETCH_EN: fetch the next batch's weights while the
// current batch runs (states PF_REQ/PF_WAIT plus pending flags).
module data_load_sequencer #(
    parameter int                ADDR_W             = 16,
    parameter int                LEN_W              = 12,
    parameter logic [ADDR_W-1:0] IFMAP_BASE         = ADDR_W'('h0000),
    parameter int                IFMAP_LAYER_WORDS  = 512,
    parameter logic [ADDR_W-1:0] WEIGHT_BASE        = ADDR_W'('h4000),
    parameter int                WEIGHT_BATCH_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  seq_start,
    input  logic                  sched_start,
    input  logic                  sched_batch_complete,
    data_load_sequencer_if.master dma,
    output logic                  ifmap_write_done,
    output logic                  weight_write_done,
    output logic [1:0]            load_layer_id,
    output logic [2:0]            load_batch_id,
    output logic                  busy,
    output logic                  seq_done,
    output logic                  protocol_err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_REQ_IFMAP,
        S_WAIT_IFMAP,
        S_REQ_WEIGHT,
        S_WAIT_WEIGHT,
        S_WAIT_START,
        S_WAIT_COMPLETE,
        S_FINISHED
`ifdef LOAD_PREFETCH_EN
        , S_PF_REQ,
        S_PF_WAIT
`endif
    } state_t;

    state_t     state, state_nx;
    logic [1:0] layer_nx;
    logic [2:0] batch_nx;
    logic       ifmap_done_nx, weight_done_nx, err_nx;
    logic       dma_ok, cmp_ok;
`ifdef LOAD_PREFETCH_EN
    logic       dma_pend, cmp_pend, dma_pend_nx, cmp_pend_nx;
`endif

    // Last batch index of each layer in the fixed schedule.
    function automatic logic [2:0] max_batch(input logic [1:0] layer);
        case (layer)
            2'd0:    max_batch = 3'd7;
            2'd1:    max_batch = 3'd3;
            default: max_batch = 3'd0;
        endcase
    endfunction

    // Weight blocks are packed back to back across layers (flat index 0..13).
    function automatic logic [ADDR_W-1:0] weight_addr(input logic [1:0] layer,
                                                      input logic [2:0] batch);
        logic [3:0]  flat_base;
        logic [31:0] offset;
        case (layer)
            2'd0:    flat_base = 4'd0;
            2'd1:    flat_base = 4'd8;
            2'd2:    flat_base = 4'd12;
            default: flat_base = 4'd13;
        endcase
        offset = 32'(flat_base + 4'(batch)) * 32'(WEIGHT_BATCH_WORDS);
        weight_addr = ADDR_W'(32'(WEIGHT_BASE) + offset);
    endfunction

    function automatic logic [ADDR_W-1:0] ifmap_addr(input logic [1:0] layer);
        ifmap_addr = ADDR_W'(32'(IFMAP_BASE) + 32'(layer) * 32'(IFMAP_LAYER_WORDS));
    endfunction

    assign busy             = (state != S_IDLE) && (state != S_FINISHED);
    assign seq_done         = (state == S_FINISHED);

    // State, layer/batch counters, done pulses and the sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            load_layer_id     <= 2'd0;
            load_batch_id     <= 3'd0;
            ifmap_write_done  <= 1'b0;
            weight_write_done <= 1'b0;
            protocol_err      <= 1'b0;
`ifdef LOAD_PREFETCH_EN
            dma_pend          <= 1'b0;
            cmp_pend          <= 1'b0;
`endif
        end else begin
            state             <= state_nx;
            load_layer_id     <= layer_nx;
            load_batch_id     <= batch_nx;
            ifmap_write_done  <= ifmap_done_nx;
            weight_write_done <= weight_done_nx;
            protocol_err      <= err_nx;
`ifdef LOAD_PREFETCH_EN
            dma_pend          <= dma_pend_nx;
            cmp_pend          <= cmp_pend_nx;
`endif
        end
    end

    // Next-state, request fields and protocol checking; request fields are a
    // pure function of state/layer/batch so they hold steady during a stall.
    always_comb begin
        state_nx          = state;
        layer_nx          = load_layer_id;
        batch_nx          = load_batch_id;
        ifmap_done_nx     = 1'b0;
        weight_done_nx    = 1'b0;
        dma_ok            = 1'b0;
        cmp_ok            = 1'b0;
        dma.dma_req_valid = 1'b0;
        dma.dma_req_type  = 1'b0;
        dma.dma_req_addr  = '0;
        dma.dma_req_len   = '0;
`ifdef LOAD_PREFETCH_EN
        dma_pend_nx       = dma_pend;
        cmp_pend_nx       = cmp_pend;
`endif
        case (state)
            S_IDLE, S_FINISHED: begin
                if (seq_start) begin
                    state_nx = S_REQ_IFMAP;
                    layer_nx = 2'd0;
                    batch_nx = 3'd0;
                end
            end
            S_REQ_IFMAP: begin
                dma.dma_req_valid = 1'b1;
                dma.dma_req_type  = 1'b1;
                dma.dma_req_addr  = ifmap_addr(load_layer_id);
                dma.dma_req_len   = LEN_W'(IFMAP_LAYER_WORDS);
                if (dma.dma_req_ready) state_nx = S_WAIT_IFMAP;
            end
            S_WAIT_IFMAP: begin
                dma_ok = 1'b1;
                if (dma.dma_done) begin
                    ifmap_done_nx = 1'b1;
                    state_nx      = S_REQ_WEIGHT;
                end
            end
            S_REQ_WEIGHT: begin
                dma.dma_req_valid = 1'b1;
                dma.dma_req_addr  = weight_addr(load_layer_id, load_batch_id);
                dma.dma_req_len   = LEN_W'(WEIGHT_BATCH_WORDS);
                if (dma.dma_req_ready) state_nx = S_WAIT_WEIGHT;
            end
            S_WAIT_WEIGHT: begin
                dma_ok = 1'b1;
                if (dma.dma_done) begin
                    weight_done_nx = 1'b1;
                    state_nx       = S_WAIT_START;
                end
            end
            S_WAIT_START: begin
                if (sched_start) begin
`ifdef LOAD_PREFETCH_EN
                    if (load_batch_id != max_batch(load_layer_id)) begin
                        state_nx    = S_PF_REQ;
                        dma_pend_nx = 1'b0;
                        cmp_pend_nx = 1'b0;
                    end else begin
                        state_nx = S_WAIT_COMPLETE;
                    end
`else
                    state_nx = S_WAIT_COMPLETE;
`endif
                end
            end
            S_WAIT_COMPLETE: begin
                cmp_ok = 1'b1;
                if (sched_batch_complete) begin
                    if (load_batch_id != max_batch(load_layer_id)) begin
                        batch_nx = load_batch_id + 3'd1;
                        state_nx = S_REQ_WEIGHT;
                    end else if (load_layer_id != 2'd3) begin
                        layer_nx = load_layer_id + 2'd1;
                        batch_nx = 3'd0;
                        state_nx = S_REQ_IFMAP;
                    end else begin
                        state_nx = S_FINISHED;
                    end
                end
            end
`ifdef LOAD_PREFETCH_EN
            S_PF_REQ: begin
                cmp_ok            = 1'b1;
                dma.dma_req_valid = 1'b1;
                dma.dma_req_addr  = weight_addr(load_layer_id, load_batch_id + 3'd1);
                dma.dma_req_len   = LEN_W'(WEIGHT_BATCH_WORDS);
                if (sched_batch_complete) cmp_pend_nx = 1'b1;
                if (dma.dma_req_ready) state_nx = S_PF_WAIT;
            end
            S_PF_WAIT: begin
                dma_ok = 1'b1;
                cmp_ok = 1'b1;
                if ((dma_pend || dma.dma_done) && (cmp_pend || sched_batch_complete)) begin
                    weight_done_nx = 1'b1;
                    batch_nx       = load_batch_id + 3'd1;
                    state_nx       = S_WAIT_START;
                    dma_pend_nx    = 1'b0;
                    cmp_pend_nx    = 1'b0;
                end else begin
                    dma_pend_nx = dma_pend || dma.dma_done;
                    cmp_pend_nx = cmp_pend || sched_batch_complete;
                end
            end
`endif
            default: state_nx = S_IDLE;
        endcase

        err_nx = protocol_err;
        if (seq_start && !busy) err_nx = 1'b0;
        if ((seq_start && busy) ||
            (dma.dma_done && !dma_ok) ||
            (sched_batch_complete && !cmp_ok) ||
            (sched_start && (state != S_WAIT_START)))
            err_nx = 1'b1;
    end

endmodule

// File: tb/tb_data_load_sequencer.sv
// tb_data_load_sequencer: randomized DMA/scheduler partner for the load
// sequencer, with an event-level reference model compared every cycle and a
// few literal expectations on addresses, latencies and status flags.
module tb_data_load_sequencer;
    localparam int ADDR_W = 16;
    localparam int LEN_W  = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       seq_start = 1'b0;
    logic       sched_start = 1'b0;
    logic       sched_batch_complete = 1'b0;
    logic       ifmap_write_done, weight_write_done, busy, seq_done, protocol_err;
    logic [1:0] load_layer_id;
    logic [2:0] load_batch_id;

    data_load_sequencer_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dma_if ();

    data_load_sequencer dut (
        .clk                  (clk),
        .rst                  (rst),
        .seq_start            (seq_start),
        .sched_start          (sched_start),
        .sched_batch_complete (sched_batch_complete),
        .dma                  (dma_if),
        .ifmap_write_done     (ifmap_write_done),
        .weight_write_done    (weight_write_done),
        .load_layer_id        (load_layer_id),
        .load_batch_id        (load_batch_id),
        .busy                 (busy),
        .seq_done             (seq_done),
        .protocol_err         (protocol_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // schedule table: sequence number k (0..13) -> layer, batch
    int s_layer[14];
    int s_batch[14];

    // reference model state (values expected after the most recent edge)
    bit m_run, m_fin, m_pend, m_out, m_pi, m_pw, m_err, m_started;
    int m_k, m_left;

    // handshake log for literal checks
    int log_addr[$];
    int log_len[$];
    int log_type[$];
    int log_layer[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare against the model, then advance the model using the inputs
    // that the next rising edge will sample.
    always @(negedge clk) begin : cmp_model
        bit o_run, o_pend, o_out, o_started;
        int o_left, o_k;
        int e_type, e_addr, e_len;
        if (chk_en) begin
            check("valid", 32'(dma_if.dma_req_valid), 32'(m_pend));
            if (m_pend) begin
                if (m_left == 2) begin
                    e_type = 1; e_addr = s_layer[m_k] * 512; e_len = 512;
                end else begin
                    e_type = 0; e_addr = 'h4000 + m_k * 256; e_len = 256;
                end
                check("req_type", 32'(dma_if.dma_req_type), 32'(e_type));
                check("req_addr", 32'(dma_if.dma_req_addr), 32'(e_addr));
                check("req_len", 32'(dma_if.dma_req_len), 32'(e_len));
            end
            check("ifmap_done", 32'(ifmap_write_done), 32'(m_pi));
            check("weight_done", 32'(weight_write_done), 32'(m_pw));
            check("layer_id", 32'(load_layer_id), 32'(s_layer[m_k]));
            check("batch_id", 32'(load_batch_id), 32'(s_batch[m_k]));
            check("busy", 32'(busy), 32'(m_run));
            check("seq_done", 32'(seq_done), 32'(m_fin));
            check("protocol_err", 32'(protocol_err), 32'(m_err));
        end
        o_run = m_run; o_pend = m_pend; o_out = m_out; o_started = m_started;
        o_left = m_left; o_k = m_k;
        m_pi = 1'b0;
        m_pw = 1'b0;
        if (rst) begin
            m_run = 0; m_fin = 0; m_pend = 0; m_out = 0; m_err = 0;
            m_started = 0; m_k = 0; m_left = 0;
        end else begin
            if (seq_start) begin
                if (!o_run) begin
                    m_run = 1; m_fin = 0; m_k = 0; m_left = 2; m_started = 0;
                    m_out = 0; m_pend = 1; m_err = 0;
                end else m_err = 1;
            end
            if (sched_start) begin
                if (o_run && o_left == 0 && !o_started) m_started = 1;
                else m_err = 1;
            end
            if (sched_batch_complete) begin
                if (o_started) begin
                    m_started = 0;
                    if (o_k < 13) begin
                        m_k = o_k + 1;
                        m_left = (s_batch[o_k + 1] == 0) ? 2 : 1;
                        m_pend = 1;
                    end else begin
                        m_run = 0; m_fin = 1;
                    end
                end else m_err = 1;
            end
            if (dma_if.dma_done) begin
                if (o_out) begin
                    m_out = 0;
                    if (o_left == 2) begin
                        m_pi = 1; m_left = 1; m_pend = 1;
                    end else begin
                        m_pw = 1; m_left = 0;
                    end
                end else m_err = 1;
            end
            if (o_pend && dma_if.dma_req_ready) begin
                m_pend = 0;
                m_out = 1;
            end
        end
    end

    // Wait (bounded) for a request, stall, accept it, then complete it.
    task automatic do_request(input bit is_ifmap, input int stall, input bit inj_start);
        int cnt = 0;
        while (dma_if.dma_req_valid !== 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
        check("req_wait_bound", 32'(cnt < 100), 32'd1);
        for (int i = 0; i < stall; i++) begin
            if (inj_start && i == 2) sched_start = 1'b1;
            tick();
            sched_start = 1'b0;
        end
        if (inj_start) check("start_in_req_err", 32'(protocol_err), 32'd1);
        dma_if.dma_req_ready = 1'b1;
        log_addr.push_back(int'(dma_if.dma_req_addr));
        log_len.push_back(int'(dma_if.dma_req_len));
        log_type.push_back(int'(dma_if.dma_req_type));
        log_layer.push_back(int'(load_layer_id));
        tick();
        dma_if.dma_req_ready = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
        dma_if.dma_done = 1'b1;
        tick();
        dma_if.dma_done = 1'b0;
        if (is_ifmap) check("ifmap_pulse_lat", 32'(ifmap_write_done), 32'd1);
        else          check("weight_pulse_lat", 32'(weight_write_done), 32'd1);
    endtask

    // mode 1: complete in WAIT_START; 2: seq_start while busy; 3: start during stall
    task automatic run_schedule(input int mode);
        log_addr.delete(); log_len.delete(); log_type.delete(); log_layer.delete();
        seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
        check("err_cleared_on_start", 32'(protocol_err), 32'd0);
        for (int k = 0; k < 14; k++) begin
            if (s_batch[k] == 0)
                do_request(1'b1, (k == 0) ? 5 : int'($urandom_range(0, 3)), 1'b0);
            do_request(1'b0, (mode == 3 && k == 5) ? 5 : int'($urandom_range(0, 3)),
                       (mode == 3 && k == 5));
            repeat ($urandom_range(0, 3)) tick();
            if (mode == 1 && k == 0) begin
                sched_batch_complete = 1'b1;
                tick();
                sched_batch_complete = 1'b0;
                check("cmp_in_wait_start_err", 32'(protocol_err), 32'd1);
                check("cmp_in_wait_start_no_req", 32'(dma_if.dma_req_valid), 32'd0);
            end
            sched_start = 1'b1;
            tick();
            sched_start = 1'b0;
            if (mode == 2 && k == 2) begin
                seq_start = 1'b1;
                tick();
                seq_start = 1'b0;
                check("seq_start_busy_err", 32'(protocol_err), 32'd1);
                check("seq_start_busy_ignored", 32'(busy), 32'd1);
            end
            repeat ($urandom_range(0, 3)) tick();
            sched_batch_complete = 1'b1;
            tick();
            sched_batch_complete = 1'b0;
            if (k < 13) begin
                check("cmp_to_valid_lat", 32'(dma_if.dma_req_valid), 32'd1);
            end else begin
                check("final_seq_done", 32'(seq_done), 32'd1);
                check("final_busy", 32'(busy), 32'd0);
            end
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int idx = 0;
        for (int l = 0; l < 4; l++) begin
            int mb;
            mb = (l == 0) ? 7 : (l == 1) ? 3 : 0;
            for (int b = 0; b <= mb; b++) begin
                s_layer[idx] = l;
                s_batch[idx] = b;
                idx++;
            end
        end
        dma_if.dma_req_ready = 1'b0;
        dma_if.dma_done      = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_valid", 32'(dma_if.dma_req_valid), 32'd0);
        check("rst_addr", 32'(dma_if.dma_req_addr), 32'd0);
        check("rst_len", 32'(dma_if.dma_req_len), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_layer", 32'(load_layer_id), 32'd0);

        // full schedule with the complete-in-WAIT_START error
        run_schedule(1);
        check("log0_addr", 32'(log_addr[0]), 32'h0000);
        check("log0_len", 32'(log_len[0]), 32'd512);
        check("log0_type", 32'(log_type[0]), 32'd1);
        check("log1_addr", 32'(log_addr[1]), 32'h4000);
        check("log1_len", 32'(log_len[1]), 32'd256);
        check("log1_type", 32'(log_type[1]), 32'd0);
        check("l0_last_weight", 32'(log_addr[8]), 32'h4700);
        check("l1_ifmap_addr", 32'(log_addr[9]), 32'h0200);
        check("l1_ifmap_layer", 32'(log_layer[9]), 32'd1);
        check("last_weight", 32'(log_addr[17]), 32'h4D00);
        check("log_count", 32'(log_addr.size()), 32'd18);

        // restart from FINISHED, reset while waiting on the weight load
        seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
        do_request(1'b1, 0, 1'b0);
        while (dma_if.dma_req_valid !== 1'b1 && idx < 200) begin
            tick();
            idx++;
        end
        dma_if.dma_req_ready = 1'b1;
        tick();
        dma_if.dma_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", 32'(dma_if.dma_req_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_err", 32'(protocol_err), 32'd0);
        dma_if.dma_done = 1'b1;
        tick();
        dma_if.dma_done = 1'b0;
        check("late_done_err", 32'(protocol_err), 32'd1);

        run_schedule(2);
        check("restart_addr", 32'(log_addr[0]), 32'h0000);
        run_schedule(3);
        check("run3_last_weight", 32'(log_addr[17]), 32'h4D00);
        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/data_load_sequencer.md
Name: data_load_sequencer

Overview:
- Producer side of the load-done handshake consumed by the batch/layer scheduler.
- Walks the fixed 4-layer transposed-conv schedule: ifmap+weight for batch 0 of each layer, then weight-only for each later batch.
- Issues load requests to the DMA/BRAM writer and emits `ifmap_write_done` / `weight_write_done` pulses.
- Paces itself on the scheduler's start and batch-complete signals.

Parameters:
- ADDR_W, 16, DMA address width.
- LEN_W, 12, DMA length width (words).
- IFMAP_BASE, 16'h0000, ifmap region base.
- IFMAP_LAYER_WORDS, 512, ifmap words per layer (also `dma_req_len` for ifmap).
- WEIGHT_BASE, 16'h4000, weight region base.
- WEIGHT_BATCH_WORDS, 256, weight words per batch (also `dma_req_len` for weight).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- seq_start  in  1  1-cycle pulse; begin schedule from layer 0 batch 0 (accepted only in IDLE/FINISHED)
- sched_start  in  1  scheduler final start pulse (batch launched)
- sched_batch_complete  in  1  scheduler batch_complete pulse
- dma_req_valid  out  1  load request valid
- dma_req_ready  in  1  DMA accepts request when valid&ready
- dma_req_type  out  1  0=weight, 1=ifmap
- dma_req_addr  out  ADDR_W  source/dest base
- dma_req_len  out  LEN_W  word count
- dma_done  in  1  1-cycle pulse, accepted request finished
- ifmap_write_done  out  1  1-cycle pulse
- weight_write_done  out  1  1-cycle pulse
- load_layer_id  out  2  layer being loaded/run
- load_batch_id  out  3  batch being loaded/run
- busy  out  1  high when state != IDLE/FINISHED
- seq_done  out  1  high in FINISHED
- protocol_err  out  1  sticky; cleared by rst or seq_start

Behaviour:
- Reset: every output 0; state IDLE; layer/batch 0.
- Max batch per layer: L0=7, L1=3, L2=0, L3=0.
- Flat weight index: L0 → 0..7, L1 → 8..11, L2 → 12, L3 → 13.
- Weight addr = WEIGHT_BASE + flat*WEIGHT_BATCH_WORDS.
- Ifmap addr = IFMAP_BASE + layer*IFMAP_LAYER_WORDS.
- Arithmetic truncates to ADDR_W.
- States:
  - IDLE: on seq_start → REQ_IFMAP, layer=0, batch=0.
  - REQ_IFMAP: valid=1, type=1. On ready → WAIT_IFMAP; valid drops the cycle after handshake.
  - WAIT_IFMAP: on dma_done → ifmap_write_done pulse next cycle → REQ_WEIGHT.
  - REQ_WEIGHT: valid=1, type=0. On ready → WAIT_WEIGHT.
  - WAIT_WEIGHT: on dma_done → weight_write_done pulse next cycle → WAIT_START.
  - WAIT_START: on sched_start → WAIT_COMPLETE.
  - WAIT_COMPLETE: on sched_batch_complete:
    - batch < max: batch+1, → REQ_WEIGHT.
    - batch == max, layer < 3: layer+1, batch=0, → REQ_IFMAP.
    - else → FINISHED.
  - FINISHED: `seq_done`=1; seq_start restarts as from IDLE.
- Request fields stay stable while valid & !ready.
- Latency: sched_batch_complete at cycle N → dma_req_valid at N+1.
- Latency: dma_done at M → done pulse at M+1.
- Any two done pulses are separated by ≥1 low cycle, as required for edge detection.
- `protocol_err` is set by any of:
  - dma_done outside WAIT_*;
  - sched_batch_complete outside WAIT_COMPLETE (or outside the prefetch states, if enabled);
  - sched_start outside WAIT_START.
  - The offending event is otherwise ignored.
- Simultaneous sched_start and sched_batch_complete in WAIT_START: start taken, complete flagged as error.
- seq_start while busy: ignored, sets protocol_err.
- rst mid-transfer: immediate return to IDLE, valid dropped; late dma_done after reset sets protocol_err.

Optional Feature:
- Macro: LOAD_PREFETCH_EN.
- Defined:
  - In WAIT_COMPLETE, when batch < max, the next weight request is issued immediately after sched_start (prefetch states PF_REQ/PF_WAIT).
  - dma_done is captured in a pending flag.
  - weight_write_done is emitted the cycle after the later of dma_done and sched_batch_complete; batch increments, then → WAIT_START.
  - Last batch of a layer is not prefetched.
- Undefined:
  - Weight loads begin only after sched_batch_complete, as above.
  - Prefetch states and pending flag are absent.

Test Plan:
- Reset, seq_start → ifmap req addr 0x0000 len 512.
  - ready+done → ifmap_write_done pulse.
  - Then weight req addr 0x4000 len 256 → weight_write_done 1 cycle after dma_done.
- Full layer 0: 8 start/complete pairs → weight addrs 0x4000..0x4700 step 0x100, load_batch_id 0..7.
  - Then ifmap req addr 0x0200, load_layer_id=1.
- Full schedule (8+4+1+1 batches) → last weight addr 0x4D00; seq_done=1 after 14th complete; busy=0.
- Hold dma_req_ready low 5 cycles → valid/addr/len stable.
  - sched_batch_complete in WAIT_START → protocol_err=1, state unchanged.
- Assert rst during WAIT_WEIGHT → all outputs 0 next cycle; subsequent seq_start restarts at 0x0000.
- With LOAD_PREFETCH_EN: dma_done before batch_complete → weight_write_done exactly 1 cycle after batch_complete.
  - No weight req issued during layer 2 (max 0).
